// File: rtl/ss_pkg.sv
// Shared opcode/state encodings, latency constants and opcode property helpers for stack_seq.
package ss_pkg;
  localparam int DSZ_DEF  = 32;
  localparam int LAT_ONE  = 1;
  localparam int LAT_SWAP = 2;
  localparam int LAT_ROT  = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_LIT = 4'd1, OP_DUP = 4'd2, OP_OVER = 4'd3, OP_DROP = 4'd4,
    OP_SWAP = 4'd5, OP_ROT = 4'd6, OP_ADD = 4'd7, OP_SUB = 4'd8, OP_AND = 4'd9,
    OP_OR = 4'd10, OP_XOR = 4'd11, OP_INV = 4'd12
  } op_e;

  typedef enum logic [2:0] {S_IDLE, S_POP1, S_POP2, S_PUSH1, S_PUSH2} state_e;

  // Live cells (TOS included) an opcode must find before it may start.
  function automatic logic [1:0] need_items(input logic [3:0] op);
    case (op)
      OP_DUP, OP_INV:                     need_items = 2'd1;
      OP_OVER, OP_DROP, OP_SWAP, OP_ADD,
      OP_SUB, OP_AND, OP_OR, OP_XOR:      need_items = 2'd2;
      OP_ROT:                             need_items = 2'd3;
      default:                            need_items = 2'd0;
    endcase
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= 4'(OP_ADD)) && (op <= 4'(OP_INV));
  endfunction

  function automatic logic net_push(input logic [3:0] op);
    return (op == 4'(OP_LIT)) || (op == 4'(OP_DUP)) || (op == 4'(OP_OVER));
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      OP_SWAP: lat_of = LAT_SWAP;
      OP_ROT:  lat_of = LAT_ROT;
      default: lat_of = LAT_ONE;
    endcase
  endfunction
endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for stack_seq: a is NOS (s0), b is TOS; SUB computes s0 - tos.
module stack_alu
  import ss_pkg::*;
#(
  parameter int DSZ = DSZ_DEF
) (
  input  logic [3:0]     i_op,
  input  logic [DSZ-1:0] i_s0,
  input  logic [DSZ-1:0] i_tos,
  output logic [DSZ-1:0] o_y
);
  always_comb begin
    case (i_op)
      OP_ADD:  o_y = i_s0 + i_tos;
      OP_SUB:  o_y = i_s0 - i_tos;
      OP_AND:  o_y = i_s0 & i_tos;
      OP_OR:   o_y = i_s0 | i_tos;
      OP_XOR:  o_y = i_s0 ^ i_tos;
      OP_INV:  o_y = ~i_tos;
      default: o_y = i_tos;
    endcase
  end
endmodule

// File: rtl/stack_seq.sv
// Stack sequencer: local TOS register driving a downstream cell stack via push/pop strobes.
// ALU opcodes exist only when STACK_SEQ_ALU_EN is defined; otherwise they complete as illegal.
module stack_seq
  import ss_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DSZ   = DSZ_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   req,
  input  logic [3:0]             op,
  input  logic [DSZ-1:0]         vi,
  output logic                   busy,
  output logic                   ack,
  output logic                   err,
  output logic [DSZ-1:0]         tos,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   ss_push,
  output logic                   ss_pop,
  output logic [DSZ-1:0]         ss_vo,
  input  logic [DSZ-1:0]         ss_s0,
  input  logic [DSZ-1:0]         ss_s1
);
  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  state_e         r_state, w_state;
  logic [3:0]     r_op, w_op;
  logic [DSZ-1:0] r_tos, w_tos, r_vo, w_vo, r_sv0, w_sv0, r_sv1, w_sv1;
  logic [DW-1:0]  r_depth, w_depth;
  logic           r_ack, w_ack, r_err, w_err, r_push, w_push, r_pop, w_pop;
  logic [DSZ-1:0] w_alu_y;
  logic           w_alu_ok, w_start, w_reject;

`ifdef STACK_SEQ_ALU_EN
  stack_alu #(.DSZ(DSZ)) u_alu (.i_op(op), .i_s0(ss_s0), .i_tos(r_tos), .o_y(w_alu_y));
  assign w_alu_ok = 1'b1;
`else
  assign w_alu_y  = r_tos;
  assign w_alu_ok = 1'b0;
`endif

  // The ack cycle blocks a new latch so the downstream stack settles before s0/s1 are read.
  assign w_start  = (r_state == S_IDLE) && req && !r_ack;
  assign w_reject = (op > 4'(OP_INV)) || (is_alu(op) && !w_alu_ok)
                  || (r_depth < DW'(need_items(op)))
                  || (net_push(op) && (r_depth == FULL));

  always_comb begin
    w_state = r_state; w_op = r_op; w_tos = r_tos; w_depth = r_depth;
    w_ack = 1'b0; w_err = 1'b0; w_push = 1'b0; w_pop = 1'b0;
    w_vo = r_vo; w_sv0 = r_sv0; w_sv1 = r_sv1;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_op = op;
        if (w_reject) begin
          w_ack = 1'b1; w_err = 1'b1;
        end else begin
          w_ack = (lat_of(op) == LAT_ONE);
          case (op)
            OP_LIT: begin
              w_tos = vi;
              if (r_depth == '0) w_depth = DW'(1);
              else begin
                w_push = 1'b1; w_vo = r_tos; w_depth = r_depth + 1'b1; w_state = S_PUSH1;
              end
            end
            OP_DUP, OP_OVER: begin
              w_push = 1'b1; w_vo = r_tos; w_depth = r_depth + 1'b1; w_state = S_PUSH1;
              if (op == 4'(OP_OVER)) w_tos = ss_s0;
            end
            OP_DROP, OP_SWAP: begin
              w_pop = 1'b1; w_tos = ss_s0; w_sv0 = r_tos; w_depth = r_depth - 1'b1; w_state = S_POP1;
            end
            OP_ROT: begin
              w_pop = 1'b1; w_sv0 = ss_s0; w_sv1 = ss_s1; w_depth = r_depth - 1'b1; w_state = S_POP1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              w_pop = 1'b1; w_tos = w_alu_y; w_depth = r_depth - 1'b1; w_state = S_POP1;
            end
            OP_INV:  w_tos = w_alu_y;
            default: ;
          endcase
        end
      end
      S_POP1: begin
        w_state = S_IDLE;
        if (r_op == 4'(OP_SWAP)) begin
          w_push = 1'b1; w_vo = r_sv0; w_depth = r_depth + 1'b1; w_ack = 1'b1; w_state = S_PUSH1;
        end else if (r_op == 4'(OP_ROT)) begin
          w_pop = 1'b1; w_depth = r_depth - 1'b1; w_state = S_POP2;
        end
      end
      S_POP2: begin
        w_push = 1'b1; w_vo = r_sv0; w_depth = r_depth + 1'b1; w_state = S_PUSH1;
      end
      S_PUSH1: begin
        w_state = S_IDLE;
        // ROT finishes by pushing old TOS (c) beneath the new TOS (a).
        if (r_op == 4'(OP_ROT)) begin
          w_push = 1'b1; w_vo = r_tos; w_tos = r_sv1; w_depth = r_depth + 1'b1;
          w_ack = 1'b1; w_state = S_PUSH2;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE; r_op <= '0; r_tos <= '0; r_depth <= '0;
      r_ack <= 1'b0; r_err <= 1'b0; r_push <= 1'b0; r_pop <= 1'b0;
      r_vo <= '0; r_sv0 <= '0; r_sv1 <= '0;
    end else if (en) begin
      r_state <= w_state; r_op <= w_op; r_tos <= w_tos; r_depth <= w_depth;
      r_ack <= w_ack; r_err <= w_err; r_push <= w_push; r_pop <= w_pop;
      r_vo <= w_vo; r_sv0 <= w_sv0; r_sv1 <= w_sv1;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign ack     = r_ack & en;
  assign err     = r_err & en;
  assign ss_push = r_push & en;
  assign ss_pop  = r_pop & en;
  assign ss_vo   = r_vo;
  assign tos     = r_tos;
  assign depth   = r_depth;
endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: directed scenarios plus random opcodes against a queue model.
module tb_stack_seq;
  import ss_pkg::*;
  localparam int DEPTH = 16;
  localparam int DSZ   = 32;

  logic clk, rst, en, req, busy, ack, err, ss_push, ss_pop;
  logic [3:0] op;
  logic [DSZ-1:0] vi, tos, ss_vo, ss_s0, ss_s1;
  logic [$clog2(DEPTH):0] depth;
  int checks, errors;
  int push_cnt = 0, pop_cnt = 0, both_cnt = 0;
  logic [DSZ-1:0] mem [DEPTH];

  stack_seq #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .op(op), .vi(vi), .busy(busy), .ack(ack),
    .err(err), .tos(tos), .depth(depth), .ss_push(ss_push), .ss_pop(ss_pop), .ss_vo(ss_vo),
    .ss_s0(ss_s0), .ss_s1(ss_s1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream cell stack: mem[0] is NOS.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ss_push) begin
      mem[0] <= ss_vo;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end else if (ss_pop) begin
      for (int i = 0; i < DEPTH-1; i++) mem[i] <= mem[i+1];
      mem[DEPTH-1] <= '0;
    end
  end
  assign ss_s0 = mem[0];
  assign ss_s1 = mem[1];

  always @(posedge clk) begin
    if (ss_push) push_cnt <= push_cnt + 1;
    if (ss_pop) pop_cnt <= pop_cnt + 1;
    if (ss_push && ss_pop) both_cnt <= both_cnt + 1;
  end

  task automatic apply_reset;
    @(negedge clk); rst = 1'b0; req = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Issues one opcode, waits (bounded) for ack, then one settle cycle; returns err, latency, strobe counts.
  task automatic do_op(input logic [3:0] o, input logic [DSZ-1:0] v, output logic e,
                       output int lat, output int np, output int npo);
    int p0, q0;
    @(negedge clk);
    p0 = push_cnt; q0 = pop_cnt;
    req = 1'b1; op = o; vi = v;
    @(negedge clk); req = 1'b0; lat = 1;
    while (ack !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
    e = err;
    @(negedge clk);
    np = push_cnt - p0; npo = pop_cnt - q0;
  endtask

  task automatic test_reset;
    rst = 1'b0; repeat (2) @(negedge clk);
    checks++; if (tos !== '0) begin errors++; $display("FAIL rst_tos got %0h exp 0", tos); end
    checks++; if (depth !== '0) begin errors++; $display("FAIL rst_depth got %0d exp 0", depth); end
    checks++; if ({busy, ack, err, ss_push, ss_pop} !== 5'b0) begin errors++;
      $display("FAIL rst_flags got %b exp 00000", {busy, ack, err, ss_push, ss_pop}); end
    checks++; if (ss_vo !== '0) begin errors++; $display("FAIL rst_vo got %0h exp 0", ss_vo); end
    rst = 1'b1; @(negedge clk);
    checks++; if ({busy, ack, depth} !== '0) begin errors++;
      $display("FAIL rst_idle got %b/%b/%0d exp 0/0/0", busy, ack, depth); end
  endtask

  task automatic test_alu;
    logic e; int lat, np, npo, pp, pq;
    apply_reset;
    do_op(4'(OP_LIT), 32'd5, e, lat, np, npo);
    checks++; if (e !== 1'b0 || lat != 1) begin errors++; $display("FAIL alu_lit5 got err=%b lat=%0d exp 0/1", e, lat); end
    do_op(4'(OP_LIT), 32'd7, e, lat, np, npo);
    checks++; if (e !== 1'b0 || lat != 1 || np != 1) begin errors++;
      $display("FAIL alu_lit7 got err=%b lat=%0d push=%0d exp 0/1/1", e, lat, np); end
    do_op(4'(OP_ADD), 32'd0, e, lat, pp, pq);
`ifdef STACK_SEQ_ALU_EN
    checks++; if (e !== 1'b0 || lat != 1) begin errors++; $display("FAIL alu_add got err=%b lat=%0d exp 0/1", e, lat); end
    checks++; if (tos !== 32'hC || depth !== 5'd1) begin errors++;
      $display("FAIL alu_res got tos=%0h depth=%0d exp c/1", tos, depth); end
    checks++; if (pq != 1 || pp != 0) begin errors++; $display("FAIL alu_pop got pop=%0d push=%0d exp 1/0", pq, pp); end
`else
    checks++; if (e !== 1'b1 || lat != 1) begin errors++; $display("FAIL noalu_add got err=%b lat=%0d exp 1/1", e, lat); end
    checks++; if (tos !== 32'd7 || depth !== 5'd2) begin errors++;
      $display("FAIL noalu_res got tos=%0h depth=%0d exp 7/2", tos, depth); end
    checks++; if (pq != 0 || pp != 0) begin errors++; $display("FAIL noalu_strobe got pop=%0d push=%0d exp 0/0", pq, pp); end
`endif
  endtask

  task automatic test_rot;
    logic e; int lat, np, npo;
    apply_reset;
    for (int i = 1; i <= 3; i++) do_op(4'(OP_LIT), DSZ'(i), e, lat, np, npo);
    do_op(4'(OP_ROT), '0, e, lat, np, npo);
    checks++; if (e !== 1'b0 || lat != 4) begin errors++; $display("FAIL rot_lat got err=%b lat=%0d exp 0/4", e, lat); end
    checks++; if (tos !== 32'd1 || mem[0] !== 32'd3 || mem[1] !== 32'd2 || depth !== 5'd3) begin errors++;
      $display("FAIL rot_stack got %0h %0h %0h d=%0d exp 1 3 2 d=3", tos, mem[0], mem[1], depth); end
  endtask

  task automatic test_underflow;
    logic e; int lat, np, npo;
    apply_reset;
    do_op(4'(OP_DROP), '0, e, lat, np, npo);
    checks++; if (e !== 1'b1 || tos !== '0 || depth !== '0 || np + npo != 0) begin errors++;
      $display("FAIL drop0 got err=%b tos=%0h d=%0d strobes=%0d exp 1/0/0/0", e, tos, depth, np + npo); end
    do_op(4'(OP_LIT), 32'h9, e, lat, np, npo);
    do_op(4'(OP_SWAP), '0, e, lat, np, npo);
    checks++; if (e !== 1'b1 || lat != 1 || tos !== 32'h9 || depth !== 5'd1 || np + npo != 0) begin errors++;
      $display("FAIL swap1 got err=%b lat=%0d tos=%0h d=%0d strobes=%0d exp 1/1/9/1/0", e, lat, tos, depth, np + npo); end
  endtask

  task automatic test_overflow;
    logic e; int lat, np, npo;
    apply_reset;
    for (int i = 0; i < DEPTH; i++) do_op(4'(OP_LIT), DSZ'(100 + i), e, lat, np, npo);
    checks++; if (depth !== 5'(DEPTH)) begin errors++; $display("FAIL fill_depth got %0d exp %0d", depth, DEPTH); end
    do_op(4'(OP_DUP), '0, e, lat, np, npo);
    checks++; if (e !== 1'b1 || depth !== 5'(DEPTH) || np != 0 || tos !== DSZ'(115)) begin errors++;
      $display("FAIL dup_full got err=%b d=%0d push=%0d tos=%0d exp 1/16/0/115", e, depth, np, tos); end
  endtask

  task automatic test_reset_mid;
    logic e; int lat, np, npo, acks;
    apply_reset;
    do_op(4'(OP_LIT), 32'h4, e, lat, np, npo);
    do_op(4'(OP_LIT), 32'h8, e, lat, np, npo);
    @(negedge clk); req = 1'b1; op = 4'(OP_SWAP);
    @(negedge clk); req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL swap_busy got %b exp 1", busy); end
    rst = 1'b0; #1;
    checks++; if (tos !== '0 || depth !== '0 || busy !== 1'b0 || ack !== 1'b0) begin errors++;
      $display("FAIL midrst got tos=%0h d=%0d busy=%b ack=%b exp 0/0/0/0", tos, depth, busy, ack); end
    @(negedge clk); rst = 1'b1; acks = 0;
    repeat (5) begin @(negedge clk); if (ack === 1'b1) acks++; end
    checks++; if (acks != 0 || depth !== '0) begin errors++; $display("FAIL midrst_ack got acks=%0d d=%0d exp 0/0", acks, depth); end
  endtask

  task automatic test_enable;
    apply_reset;
    @(negedge clk); en = 1'b0; req = 1'b1; op = 4'(OP_LIT); vi = 32'hABCD;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 1'b0 || depth !== '0 || ss_push !== 1'b0) begin errors++;
      $display("FAIL en_stall got ack=%b d=%0d push=%b exp 0/0/0", ack, depth, ss_push); end
    en = 1'b1; @(negedge clk); req = 1'b0;
    checks++; if (ack !== 1'b1 || depth !== 5'd1 || tos !== 32'hABCD) begin errors++;
      $display("FAIL en_resume got ack=%b d=%0d tos=%0h exp 1/1/abcd", ack, depth, tos); end
  endtask

  task automatic test_back_to_back;
    int acks;
    apply_reset;
    @(negedge clk); req = 1'b1; op = 4'(OP_NOP); acks = 0;
    repeat (6) begin @(negedge clk); if (ack === 1'b1) acks++; end
    req = 1'b0; @(negedge clk);
    checks++; if (acks != 3) begin errors++; $display("FAIL b2b_acks got %0d exp 3", acks); end
  endtask

  task automatic test_random;
    logic [DSZ-1:0] m[$];
    logic [DSZ-1:0] v, a, b, c, x, exp_tos;
    logic [3:0] o;
    logic e, e_err, ok;
    int lat, np, npo, e_lat, e_pu, e_po, need;
    bit illegal, grows;
    apply_reset;
    m.delete();
    for (int n = 0; n < 250; n++) begin
      o = ($urandom_range(2, 0) == 0) ? 4'(OP_LIT) : 4'($urandom_range(15, 0));
      v = $urandom;
      case (o)
        OP_DUP, OP_INV: need = 1;
        OP_ROT: need = 3;
        OP_OVER, OP_DROP, OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: need = 2;
        default: need = 0;
      endcase
      grows = (o == 4'(OP_LIT)) || (o == 4'(OP_DUP)) || (o == 4'(OP_OVER));
`ifdef STACK_SEQ_ALU_EN
      illegal = (o > 4'd12);
`else
      illegal = (o >= 4'd7);
`endif
      e_err = 1'b0; e_lat = 1; e_pu = 0; e_po = 0;
      if (illegal || m.size() < need || (grows && m.size() == DEPTH)) e_err = 1'b1;
      else case (o)
        OP_LIT:  begin e_pu = (m.size() > 0) ? 1 : 0; m.push_front(v); end
        OP_DUP:  begin e_pu = 1; m.push_front(m[0]); end
        OP_OVER: begin e_pu = 1; m.push_front(m[1]); end
        OP_DROP: begin e_po = 1; void'(m.pop_front()); end
        OP_SWAP: begin e_pu = 1; e_po = 1; e_lat = 2; a = m[0]; m[0] = m[1]; m[1] = a; end
        OP_ROT:  begin e_pu = 2; e_po = 2; e_lat = 4; c = m[0]; b = m[1]; a = m[2];
                       m[0] = a; m[1] = c; m[2] = b; end
        OP_INV:  m[0] = ~m[0];
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          e_po = 1; a = m[1]; b = m[0];
          case (o)
            OP_ADD: x = a + b;
            OP_SUB: x = a - b;
            OP_AND: x = a & b;
            OP_OR:  x = a | b;
            default: x = a ^ b;
          endcase
          void'(m.pop_front()); m[0] = x;
        end
        default: ;
      endcase
      do_op(o, v, e, lat, np, npo);
      exp_tos = (m.size() > 0) ? m[0] : '0;
      checks++; if (e !== e_err || lat != e_lat) begin errors++;
        $display("FAIL rnd%0d_ack op=%0d got err=%b lat=%0d exp %b/%0d", n, o, e, lat, e_err, e_lat); end
      checks++; if (np != e_pu || npo != e_po) begin errors++;
        $display("FAIL rnd%0d_strobe op=%0d got push=%0d pop=%0d exp %0d/%0d", n, o, np, npo, e_pu, e_po); end
      checks++; if (depth !== 5'(m.size()) || tos !== exp_tos) begin errors++;
        $display("FAIL rnd%0d_top op=%0d got d=%0d tos=%0h exp %0d/%0h", n, o, depth, tos, m.size(), exp_tos); end
      ok = 1'b1;
      for (int i = 1; i < m.size(); i++) if (mem[i-1] !== m[i]) ok = 1'b0;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd%0d_cells op=%0d got mismatched cells exp model", n, o); end
    end
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL both_strobes got %0d exp 0", both_cnt); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; en = 1'b1; req = 1'b0; op = '0; vi = '0;
    test_reset;
    test_alu;
    test_rot;
    test_underflow;
    test_overflow;
    test_reset_mid;
    test_enable;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
